axi4_sram_slave_dp: RTL and testbench
=====================================

# axi4_sram_slave_dp

Parametrised AXI4 slave that fronts a simple-dual-port, byte-writable on-chip SRAM, with independent read and write channel engines so read and write bursts proceed concurrently. Supports FIXED/INCR/WRAP bursts, narrow transfers, configurable data/address/ID width and depth, and SLVERR on out-of-range or illegal requests. Sits on the AXI interconnect as a memory target, replacing the single-FSM half-duplex SRAM wrapper.

## Interface
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; 32, 64 or 128.
- ID_W, 8: AXI ID width.
- DEPTH, 16384: SRAM words of DATA_W bits; power of two.
- ACLK  in  1  clock; all logic rising-edge.
- ARESETn  in  1  reset, asynchronous, active-low.
- AW*: AWID[ID_W], AWADDR[ADDR_W], AWLEN[8], AWSIZE[3], AWBURST[2], AWVALID in; AWREADY out.
- W*: WDATA[DATA_W], WSTRB[DATA_W/8], WLAST, WVALID in; WREADY out.
- B*: BID[ID_W], BRESP[2], BVALID out; BREADY in.
- AR*: ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID in; ARREADY out.
- R*: RID[ID_W], RDATA[DATA_W], RRESP[2], RLAST, RVALID out; RREADY in.

## Operation
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE. AWREADY=1 only in W_IDLE; AW handshake latches ID/addr/len/size/burst, clears beat count and error flag. W_DATA: WREADY=1; each W handshake writes WDATA under WSTRB to current word, advances address. Handshake with WLAST (or beat count == len) -> W_RESP. W_RESP: BVALID=1, BRESP=SLVERR if any beat erred else OKAY; leave on BREADY.
- Read FSM R_IDLE -> R_READ -> R_VALID. ARREADY=1 only in R_IDLE. R_READ issues synchronous SRAM read. R_VALID: RVALID=1, RDATA registered and stable until RREADY; RLAST=1 on beat len. On handshake: last -> R_IDLE, else advance address -> R_READ.
- Address generation (byte address A, B=2^size): FIXED next=A; INCR next=(A & ~(B-1))+B; WRAP: W=(len+1)*B, next=(A & ~(W-1)) | ((A+B) & (W-1)). First beat uses A unaligned; word index = A >> log2(DATA_W/8).
- Errors (SLVERR=2'b10): word index >= DEPTH (per beat; write suppressed, RDATA=0); burst=2'b11 (treated FIXED); WRAP with len not in {1,3,7,15} (treated INCR); size > log2(DATA_W/8) (treated full width). Illegal-request errors apply to every beat.
- Simultaneous write and read to same word in one cycle: read returns old data.
- WLAST before beat len, or missing at beat len: burst ends at first of the two; BRESP=SLVERR.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0; BRESP, RRESP = 0; BID, RID, RDATA = 0. All are flops; AWREADY/ARREADY rise at first edge after reset deassertion.
- Reset mid-burst: both FSMs to idle immediately; partial writes already committed stay; no B/R completion.
- Write: AW handshake edge -> WREADY at next edge; one beat per cycle; BVALID edge after last W beat.
- Read: AR handshake -> RVALID 2 edges later; sustained 1 beat per 2 cycles; RREADY low holds RVALID/RDATA/RLAST/RRESP.
- Read and write channels fully independent; no arbitration, no stall of one by the other.

## Structure
- Package axi4_sram_pkg: burst enum (FIXED/INCR/WRAP), RESP_OKAY/RESP_SLVERR, state enums, next-address function.
- Sub-module axi_burst_addr_gen (addr, size, len, burst -> next addr, illegal flag), instantiated once per channel.
- Memory: behavioural simple-dual-port array with byte enables, one write and one read port.

## Test plan
- INCR len=3 size=2 write 0x100 data 11,22,33,44 then read -> RDATA 11,22,33,44, RLAST on beat 4, both OKAY, BID/RID echo IDs.
- WRAP len=3 size=2 at 0x10C -> beat addresses 0x10C,0x100,0x104,0x108; readback confirms.
- FIXED len=3 WSTRB=0001,0010,0100,1000 to 0x40 -> word 0x40 holds all four bytes merged.
- Write to word DEPTH -> BRESP=SLVERR, memory unchanged; read there -> RDATA=0, RRESP=SLVERR.
- Concurrent 8-beat write and 8-beat read to disjoint regions with RREADY toggling -> both complete, RDATA held stable while RREADY=0.
- ARESETn low during beat 2 of write -> all outputs reset values; beats 0-1 present, later beats absent.

Source files
------------

// File: rtl/axi4_sram_pkg.sv
// Shared types, response codes and burst address arithmetic for the AXI4 SRAM slave.
package axi4_sram_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_READ  = 2'd1,
        R_VALID = 2'd2
    } r_state_e;

    // Next byte address of a burst; size/len/burst must already be legalised.
    function automatic logic [63:0] axi_next_addr(input logic [63:0] addr,
                                                  input logic [2:0]  size,
                                                  input logic [7:0]  len,
                                                  input burst_e      burst);
        logic [63:0] bytes;
        logic [63:0] wrap_bytes;
        bytes      = 64'd1 << size;
        wrap_bytes = bytes * (64'(len) + 64'd1);
        case (burst)
            BURST_FIXED: axi_next_addr = addr;
            BURST_WRAP:  axi_next_addr = (addr & ~(wrap_bytes - 64'd1)) |
                                         ((addr + bytes) & (wrap_bytes - 64'd1));
            default:     axi_next_addr = (addr & ~(bytes - 64'd1)) + bytes;
        endcase
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Legalises a burst request and computes the address of the following beat.
module axi_burst_addr_gen
    import axi4_sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [2:0]        size_i,
    input  logic [7:0]        len_i,
    input  logic [1:0]        burst_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              illegal_o
);
    localparam int MAX_SIZE = $clog2(DATA_W / 8);

    logic       bad_size_s;
    logic       bad_burst_s;
    logic       bad_wrap_s;
    logic [2:0] eff_size_s;
    logic [1:0] eff_burst_s;

    // Illegal requests are still served: reserved burst as FIXED, odd WRAP length as INCR,
    // oversize beats as full bus width; every beat of such a burst reports SLVERR.
    always_comb begin
        bad_size_s  = (size_i > 3'(MAX_SIZE));
        bad_burst_s = (burst_i == BURST_RSVD);
        bad_wrap_s  = (burst_i == BURST_WRAP) &&
                      !((len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15));
        eff_size_s  = bad_size_s ? 3'(MAX_SIZE) : size_i;
        if (bad_burst_s) begin
            eff_burst_s = BURST_FIXED;
        end else if (bad_wrap_s) begin
            eff_burst_s = BURST_INCR;
        end else begin
            eff_burst_s = burst_i;
        end
        next_addr_o = ADDR_W'(axi_next_addr(64'(addr_i), eff_size_s, len_i, burst_e'(eff_burst_s)));
        illegal_o   = bad_size_s | bad_burst_s | bad_wrap_s;
    end

endmodule

// File: rtl/axi4_sram_slave_dp.sv
// AXI4 slave over a simple-dual-port byte-writable SRAM; read and write engines run concurrently.
module axi4_sram_slave_dp
    import axi4_sram_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 8,
    parameter int DEPTH  = 16384
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic [ID_W-1:0]     AWID,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [7:0]          AWLEN,
    input  logic [2:0]          AWSIZE,
    input  logic [1:0]          AWBURST,
    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,
    input  logic                WLAST,
    input  logic                WVALID,
    output logic                WREADY,
    output logic [ID_W-1:0]     BID,
    output logic [1:0]          BRESP,
    output logic                BVALID,
    input  logic                BREADY,
    input  logic [ID_W-1:0]     ARID,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [7:0]          ARLEN,
    input  logic [2:0]          ARSIZE,
    input  logic [1:0]          ARBURST,
    input  logic                ARVALID,
    output logic                ARREADY,
    output logic [ID_W-1:0]     RID,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic                RLAST,
    output logic                RVALID,
    input  logic                RREADY
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Write channel state
    w_state_e          w_state_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [7:0]        aw_len_q;
    logic [7:0]        w_cnt_q;
    logic [2:0]        aw_size_q;
    logic [1:0]        aw_burst_q;
    logic              w_err_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [1:0]        bresp_q;
    logic [ID_W-1:0]   bid_q;

    // Read channel state
    r_state_e          r_state_q;
    logic [ID_W-1:0]   ar_id_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [7:0]        ar_len_q;
    logic [7:0]        r_cnt_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;
    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [1:0]        rresp_q;
    logic [ID_W-1:0]   rid_q;
    logic [DATA_W-1:0] rdata_q;

    logic [ADDR_W-1:0] w_next_s, r_next_s;
    logic              w_illegal_s, r_illegal_s;
    logic [ADDR_W-1:0] w_word_s, r_word_s;
    logic [IDX_W-1:0]  w_idx_s, r_idx_s;
    logic              w_hs_s, w_beat_err_s, w_at_len_s, w_last_s, w_mismatch_s, mem_we_s;
    logic              r_err_s;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_w_addr (
        .addr_i      (aw_addr_q),
        .size_i      (aw_size_q),
        .len_i       (aw_len_q),
        .burst_i     (aw_burst_q),
        .next_addr_o (w_next_s),
        .illegal_o   (w_illegal_s)
    );

    axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_r_addr (
        .addr_i      (ar_addr_q),
        .size_i      (ar_size_q),
        .len_i       (ar_len_q),
        .burst_i     (ar_burst_q),
        .next_addr_o (r_next_s),
        .illegal_o   (r_illegal_s)
    );

    assign w_hs_s       = WVALID & wready_q;
    assign w_word_s     = aw_addr_q >> OFFS;
    assign w_idx_s      = w_word_s[IDX_W-1:0];
    assign w_beat_err_s = w_illegal_s | (w_word_s >= ADDR_W'(DEPTH));
    assign w_at_len_s   = (w_cnt_q == aw_len_q);
    // The burst ends at WLAST or at beat len, whichever comes first; disagreement is an error.
    assign w_last_s     = WLAST | w_at_len_s;
    assign w_mismatch_s = WLAST ^ w_at_len_s;
    assign mem_we_s     = w_hs_s & ~(w_illegal_s | (w_word_s >= ADDR_W'(DEPTH)));

    assign r_word_s     = ar_addr_q >> OFFS;
    assign r_idx_s      = r_word_s[IDX_W-1:0];
    assign r_err_s      = r_illegal_s | (r_word_s >= ADDR_W'(DEPTH));

    // SRAM write port: byte-masked write of the current beat, out-of-range beats dropped.
    always_ff @(posedge ACLK) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (WSTRB[b]) begin
                    mem_q[w_idx_s][8*b +: 8] <= WDATA[8*b +: 8];
                end
            end
        end
    end

    // Write engine: accept AW, consume W beats, return B.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state_q  <= W_IDLE;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= 8'd0;
            w_cnt_q    <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            bid_q      <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        aw_id_q    <= AWID;
                        aw_addr_q  <= AWADDR;
                        aw_len_q   <= AWLEN;
                        aw_size_q  <= AWSIZE;
                        aw_burst_q <= AWBURST;
                        w_cnt_q    <= 8'd0;
                        w_err_q    <= 1'b0;
                        awready_q  <= 1'b0;
                        wready_q   <= 1'b1;
                        w_state_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        if (w_last_s) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= aw_id_q;
                            bresp_q   <= (w_err_q | w_beat_err_s | w_mismatch_s) ? RESP_SLVERR : RESP_OKAY;
                            w_state_q <= W_RESP;
                        end else begin
                            aw_addr_q <= w_next_s;
                            w_cnt_q   <= w_cnt_q + 8'd1;
                            w_err_q   <= w_err_q | w_beat_err_s;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY && bvalid_q) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: begin
                    wready_q  <= 1'b0;
                    bvalid_q  <= 1'b0;
                    w_state_q <= W_IDLE;
                end
            endcase
        end
    end

    // Read engine: accept AR, one synchronous SRAM read per beat, hold R until accepted.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state_q  <= R_IDLE;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= 8'd0;
            r_cnt_q    <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rid_q      <= '0;
            rdata_q    <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        ar_id_q    <= ARID;
                        ar_addr_q  <= ARADDR;
                        ar_len_q   <= ARLEN;
                        ar_size_q  <= ARSIZE;
                        ar_burst_q <= ARBURST;
                        r_cnt_q    <= 8'd0;
                        arready_q  <= 1'b0;
                        r_state_q  <= R_READ;
                    end
                end
                R_READ: begin
                    // Same-cycle write to this word is not yet visible: old data is returned.
                    rdata_q   <= r_err_s ? '0 : mem_q[r_idx_s];
                    rresp_q   <= r_err_s ? RESP_SLVERR : RESP_OKAY;
                    rlast_q   <= (r_cnt_q == ar_len_q);
                    rid_q     <= ar_id_q;
                    rvalid_q  <= 1'b1;
                    r_state_q <= R_VALID;
                end
                R_VALID: begin
                    if (RREADY && rvalid_q) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            ar_addr_q <= r_next_s;
                            r_cnt_q   <= r_cnt_q + 8'd1;
                            r_state_q <= R_READ;
                        end
                    end
                end
                default: begin
                    rvalid_q  <= 1'b0;
                    r_state_q <= R_IDLE;
                end
            endcase
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = bid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RRESP   = rresp_q;
    assign RID     = rid_q;
    assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi4_sram_slave_dp.sv
// Randomised self-checking bench for axi4_sram_slave_dp against a word-array reference model.
module tb_axi4_sram_slave_dp;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 8;
    localparam int DEPTH  = 256;

    logic              ACLK, ARESETn;
    logic [ID_W-1:0]   AWID, ARID, BID, RID;
    logic [ADDR_W-1:0] AWADDR, ARADDR;
    logic [7:0]        AWLEN, ARLEN;
    logic [2:0]        AWSIZE, ARSIZE;
    logic [1:0]        AWBURST, ARBURST, BRESP, RRESP;
    logic              AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DATA_W-1:0] WDATA, RDATA;
    logic [3:0]        WSTRB;

    axi4_sram_slave_dp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] wdat [0:15];
    logic [3:0]  wstb [0:15];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit wrap_len_ok(input int len);
        return (len == 1) || (len == 3) || (len == 7) || (len == 15);
    endfunction

    function automatic bit req_illegal(input int size, input int len, input int burst);
        return (burst == 3) || (burst == 2 && !wrap_len_ok(len)) || (size > 2);
    endfunction

    // Byte address of beat i, computed in closed form from the burst start.
    function automatic longint unsigned beat_addr(input longint unsigned a, input int size,
                                                  input int len, input int burst, input int i);
        int sz;
        int bt;
        longint unsigned b, w, base;
        sz = (size > 2) ? 2 : size;
        bt = burst;
        if (bt == 3) bt = 0;
        else if (bt == 2 && !wrap_len_ok(len)) bt = 1;
        b = 64'd1 << sz;
        case (bt)
            0: return a;
            2: begin
                w    = b * 64'(len + 1);
                base = a & ~(w - 64'd1);
                return base + (((a - base) + 64'(i) * b) % w);
            end
            default: return (i == 0) ? a : (a & ~(b - 64'd1)) + 64'(i) * b;
        endcase
    endfunction

    function automatic bit beat_err(input longint unsigned a, input int size, input int len, input int burst);
        return req_illegal(size, len, burst) || ((a >> 2) >= DEPTH);
    endfunction

    // ---------------- channel drivers ----------------
    task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = 3'(size); AWBURST = 2'(burst);
        AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && n < 200) begin @(posedge ACLK); #1; n++; end
        chk("aw_ready", 64'(AWREADY), 64'd1);
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic last);
        int n = 0;
        WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
        while (WREADY !== 1'b1 && n < 200) begin @(posedge ACLK); #1; n++; end
        chk("w_ready", 64'(WREADY), 64'd1);
        @(posedge ACLK); #1;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic model_write(input longint unsigned a, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
        end
    endtask

    // wlast_at: beat carrying WLAST (a value above len means WLAST is never sent).
    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input int wlast_at, input int gap_max);
        int last_i;
        int n;
        bit err;
        longint unsigned a;
        last_i = (wlast_at < len) ? wlast_at : len;
        err    = (wlast_at != len);
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i <= last_i; i++) begin
            repeat ($urandom_range(0, gap_max)) begin @(posedge ACLK); #1; end
            send_w(wdat[i], wstb[i], (i == wlast_at));
            a = beat_addr(64'(addr), size, len, burst, i);
            if (beat_err(a, size, len, burst)) err = 1'b1;
            else model_write(a, wdat[i], wstb[i]);
        end
        chk("b_lat", 64'(BVALID), 64'd1);
        repeat ($urandom_range(0, 2)) begin @(posedge ACLK); #1; end
        n = 0;
        while (BVALID !== 1'b1 && n < 200) begin @(posedge ACLK); #1; n++; end
        chk("b_valid", 64'(BVALID), 64'd1);
        chk("b_id", 64'(BID), 64'(id));
        chk("b_resp", 64'(BRESP), err ? 64'd2 : 64'd0);
        BREADY = 1'b1;
        @(posedge ACLK); #1;
        BREADY = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input int hold_max);
        int n;
        bit e;
        longint unsigned a;
        logic [31:0] exp_d;
        n = 0;
        ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = 3'(size); ARBURST = 2'(burst);
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && n < 200) begin @(posedge ACLK); #1; n++; end
        chk("ar_ready", 64'(ARREADY), 64'd1);
        @(posedge ACLK); #1;
        ARVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            n = 0;
            while (RVALID !== 1'b1 && n < 200) begin @(posedge ACLK); #1; n++; end
            chk("r_valid", 64'(RVALID), 64'd1);
            chk("r_lat", 64'(n), 64'd1);
            a     = beat_addr(64'(addr), size, len, burst, i);
            e     = beat_err(a, size, len, burst);
            exp_d = e ? 32'd0 : ref_mem[int'(a >> 2)];
            chk("r_data", 64'(RDATA), 64'(exp_d));
            chk("r_resp", 64'(RRESP), e ? 64'd2 : 64'd0);
            chk("r_last", 64'(RLAST), 64'(i == len));
            chk("r_id", 64'(RID), 64'(id));
            repeat ($urandom_range(0, hold_max)) begin
                @(posedge ACLK); #1;
                chk("r_hold_valid", 64'(RVALID), 64'd1);
                chk("r_hold_data", 64'(RDATA), 64'(exp_d));
            end
            RREADY = 1'b1;
            @(posedge ACLK); #1;
            RREADY = 1'b0;
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_awready", 64'(AWREADY), 64'd0);
        chk("rst_wready", 64'(WREADY), 64'd0);
        chk("rst_bvalid", 64'(BVALID), 64'd0);
        chk("rst_arready", 64'(ARREADY), 64'd0);
        chk("rst_rvalid", 64'(RVALID), 64'd0);
        chk("rst_rlast", 64'(RLAST), 64'd0);
        chk("rst_bresp", 64'(BRESP), 64'd0);
        chk("rst_rresp", 64'(RRESP), 64'd0);
        chk("rst_bid", 64'(BID), 64'd0);
        chk("rst_rid", 64'(RID), 64'd0);
        chk("rst_rdata", 64'(RDATA), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lens [5];
        int len, size, burst, wl;
        logic [31:0] addr;
        lens = '{0, 1, 3, 7, 15};

        ARESETn = 1'b0;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        chk_reset_outs();
        ARESETn = 1'b1;
        chk("awready_pre", 64'(AWREADY), 64'd0);
        @(posedge ACLK); #1;
        chk("awready_up", 64'(AWREADY), 64'd1);
        chk("arready_up", 64'(ARREADY), 64'd1);

        // Give every word a known value.
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
            do_write(8'(k), 32'(k * 64), 15, 2, 1, 15, 0);
        end

        // INCR len 3 at 0x100 and readback.
        wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
        for (int i = 0; i < 4; i++) wstb[i] = 4'hF;
        do_write(8'hA5, 32'h100, 3, 2, 1, 3, 0);
        do_read(8'h5A, 32'h100, 3, 2, 1, 0);

        // WRAP len 3 at 0x10C.
        for (int i = 0; i < 4; i++) wdat[i] = $urandom;
        do_write(8'h21, 32'h10C, 3, 2, 2, 3, 1);
        do_read(8'h22, 32'h100, 3, 2, 1, 1);
        do_read(8'h23, 32'h10C, 3, 2, 2, 1);

        // FIXED with walking byte strobes at 0x40.
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'(1 << i); end
        do_write(8'h30, 32'h40, 3, 2, 0, 3, 0);
        do_read(8'h31, 32'h40, 0, 2, 1, 0);

        // Out-of-range word DEPTH; word 0 must not be aliased.
        wdat[0] = 32'hDEADBEEF; wstb[0] = 4'hF;
        do_write(8'h40, 32'(DEPTH * 4), 0, 2, 1, 0, 0);
        do_read(8'h41, 32'(DEPTH * 4), 0, 2, 1, 0);
        do_read(8'h42, 32'h0, 0, 2, 1, 0);

        // Early WLAST and missing WLAST.
        for (int i = 0; i < 8; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        do_write(8'h50, 32'h200, 7, 2, 1, 2, 0);
        do_read(8'h51, 32'h200, 7, 2, 1, 0);
        for (int i = 0; i < 4; i++) wdat[i] = $urandom;
        do_write(8'h52, 32'h220, 3, 2, 1, 255, 0);
        do_read(8'h53, 32'h220, 3, 2, 1, 0);

        // Random sequential traffic, including illegal and out-of-range requests.
        for (int t = 0; t < 60; t++) begin
            len   = ($urandom_range(0, 1) == 1) ? lens[$urandom_range(0, 4)] : int'($urandom_range(0, 15));
            size  = $urandom_range(0, 3);
            burst = $urandom_range(0, 3);
            addr  = $urandom_range(0, 32'h47F);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(0, 15)); end
                wl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : len;
                do_write(8'($urandom), addr, len, size, burst, wl, 1);
            end else begin
                do_read(8'($urandom), addr, len, size, burst, 2);
            end
        end

        // Concurrent write (lower half) and read (upper half) with RREADY stalls.
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstb[i] = 4'($urandom_range(1, 15)); end
            fork
                do_write(8'($urandom), 32'($urandom_range(0, 100) * 4), 7, 2, int'($urandom_range(0, 2)), 7, 0);
                do_read(8'($urandom), 32'($urandom_range(128, 230) * 4), 7, int'($urandom_range(0, 2)),
                        int'($urandom_range(0, 2)), 3);
            join
        end

        // Reset during beat 2 of a 4-beat write.
        for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstb[i] = 4'hF; end
        send_aw(8'h77, 32'h300, 3, 2, 1);
        send_w(wdat[0], 4'hF, 1'b0); model_write(64'h300, wdat[0], 4'hF);
        send_w(wdat[1], 4'hF, 1'b0); model_write(64'h304, wdat[1], 4'hF);
        WDATA = wdat[2]; WSTRB = 4'hF; WVALID = 1'b1;
        #2;
        ARESETn = 1'b0;
        #1;
        chk_reset_outs();
        WVALID = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        chk("awready_rst", 64'(AWREADY), 64'd0);
        @(posedge ACLK); #1;
        chk("awready_rec", 64'(AWREADY), 64'd1);
        do_read(8'h78, 32'h300, 3, 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
